// File: rtl/hwag_gap_detect.sv
// hwag_gap_detect
//   Crank-wheel front end of the hardware angle generator. Synchronises the
//   raw crank tooth input, measures the clock-cycle period between accepted
//   teeth, detects the missing-tooth gap of a 60-2 style wheel and tracks the
//   tooth index used by the downstream angle counter.
//
// Parameters
//   WIDTH    period counter / period output width
//   TOOTH_W  tooth index width
//   TEETH    physical teeth per revolution (indices 0..TEETH-1)
//
// Ports
//   clk           system clock, rising edge
//   srst          synchronous active-high reset; overrides everything
//   cap_in        raw asynchronous crank signal, a tooth is its rising edge
//   tooth_edge    one-cycle pulse per accepted tooth edge
//   period        clocks between the last two accepted edges
//   period_valid  period holds a real measurement
//   gap           one-cycle pulse with tooth_edge when the edge closes a gap
//   tooth_num     index of the last accepted tooth, 0 = first after the gap
//   synced        high in the SYNCED state
//   sync_lost     one-cycle pulse when leaving SYNCED
//   ovf           sticky period-counter saturation flag, cleared by next edge
//   state_dbg     current FSM state (IDLE=0, MEAS=1, HUNT=2, SYNCED=3)
//
// Build option
//   HWAG_GAP_NOISE_REJECT_EN: when defined, edges arriving earlier than a
//   quarter of the previous period (with a valid period) are dropped as noise.
//
// Latency: cap_in first sampled high at edge k -> outputs update at edge k+3
// (two synchroniser stages, one history/edge stage, one output register).
module hwag_gap_detect #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned TOOTH_W = 6,
  parameter int unsigned TEETH   = 58
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               cap_in,
  output logic               tooth_edge,
  output logic [WIDTH-1:0]   period,
  output logic               period_valid,
  output logic               gap,
  output logic [TOOTH_W-1:0] tooth_num,
  output logic               synced,
  output logic               sync_lost,
  output logic               ovf,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    HUNT   = 2'd2,
    SYNCED = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   CNT_PRE  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0]   CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TOOTH_W-1:0] LAST_TN  = TOOTH_W'(TEETH - 1);

  state_t             state, state_nx;
  logic               s1, s2, s3, edge_q;
  logic [WIDTH-1:0]   cnt, cnt_nx, period_nx;
  logic [TOOTH_W-1:0] tn_nx;
  logic               pv_nx, ovf_nx, te_nx, gap_nx, sl_nx;
  logic               is_gap, reject, accept;

  // The period register doubles as the "previous period": both update on
  // exactly the same accepted edges, so a separate copy would always match.
  // The doubled value is formed at WIDTH+1 bits so it cannot wrap.
  assign is_gap = ({1'b0, cnt} >= {period, 1'b0});

`ifdef HWAG_GAP_NOISE_REJECT_EN
  assign reject = period_valid && (cnt < (period >> 2));
`else
  assign reject = 1'b0;
`endif

  assign accept    = edge_q && !reject;
  assign state_dbg = state;

  // Synchroniser, history register and registered edge detect.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1     <= cap_in;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 && !s3;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      tooth_num    <= '0;
      ovf          <= 1'b0;
      tooth_edge   <= 1'b0;
      gap          <= 1'b0;
      sync_lost    <= 1'b0;
      synced       <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      period       <= period_nx;
      period_valid <= pv_nx;
      tooth_num    <= tn_nx;
      ovf          <= ovf_nx;
      tooth_edge   <= te_nx;
      gap          <= gap_nx;
      sync_lost    <= sl_nx;
      synced       <= (state_nx == SYNCED);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    period_nx = period;
    pv_nx     = period_valid;
    tn_nx     = tooth_num;
    ovf_nx    = ovf;
    te_nx     = 1'b0;
    gap_nx    = 1'b0;
    sl_nx     = 1'b0;

    if (accept) begin
      te_nx     = 1'b1;
      period_nx = cnt;
      cnt_nx    = CNT_ONE;
      ovf_nx    = 1'b0;
      case (state)
        IDLE: state_nx = MEAS;
        MEAS: begin
          pv_nx    = 1'b1;
          state_nx = HUNT;
        end
        HUNT: begin
          tn_nx = '0;
          if (is_gap) begin
            gap_nx   = 1'b1;
            state_nx = SYNCED;
          end
        end
        SYNCED: begin
          if (is_gap) begin
            tn_nx = '0;
            if (tooth_num == LAST_TN) begin
              gap_nx = 1'b1;
            end else begin
              sl_nx    = 1'b1;
              state_nx = HUNT;
            end
          end else if (tooth_num == LAST_TN) begin
            // A gap was due here; a normal tooth means the count slipped.
            tn_nx    = '0;
            sl_nx    = 1'b1;
            state_nx = HUNT;
          end else begin
            tn_nx = tooth_num + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Counter runs between edges; reaching all-ones means the wheel
      // stopped or slowed beyond range, so restart acquisition.
      if (cnt == CNT_PRE) begin
        cnt_nx   = CNT_MAX;
        ovf_nx   = 1'b1;
        pv_nx    = 1'b0;
        state_nx = IDLE;
        sl_nx    = (state == SYNCED);
      end else if (cnt != CNT_MAX) begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hwag_gap_detect.md
# hwag_gap_detect

Crank-wheel front end of the hardware angle generator: synchronises the raw crank tooth input, measures the clock-cycle period between consecutive teeth, detects the missing-tooth gap (60-2 style wheel) and tracks tooth position. Its `tooth_edge`, `gap` and `tooth_num` outputs drive the enable and synchronous-load inputs of the downstream angle counter, which interpolates angle within a tooth.

## Interface
Parameters:
- `WIDTH`, 24: period counter and period output width.
- `TOOTH_W`, 6: tooth index width.
- `TEETH`, 58: physical teeth per revolution; valid tooth indices are 0..TEETH-1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `srst`  in  1  synchronous active-high reset.
- `cap_in`  in  1  raw crank tooth signal, asynchronous; a tooth is its rising edge.
- `tooth_edge`  out  1  one-cycle pulse per accepted tooth edge.
- `period`  out  WIDTH  clocks between the last two accepted edges.
- `period_valid`  out  1  high once `period` holds a real measurement.
- `gap`  out  1  one-cycle pulse, coincident with `tooth_edge`, when the edge closes a gap.
- `tooth_num`  out  TOOTH_W  index of the last accepted tooth; 0 is the first tooth after the gap.
- `synced`  out  1  high in the SYNCED state.
- `sync_lost`  out  1  one-cycle pulse when leaving SYNCED for any reason.
- `ovf`  out  1  sticky; high when the period counter saturated; cleared by the next accepted edge.

## Operation
- **Input sync:** `cap_in` passes through a 2-FF synchroniser plus one history register. An edge is defined as stage2 high while stage3 is low.
- **Period counter `cnt`:**
  - On an accepted edge: `period` takes `cnt`, then `cnt` reloads to 1.
  - Otherwise `cnt` increments, saturating at all-ones.
  - Result: edges N clocks apart give `period` = N.
- **Gap rule:** the edge is a gap when `cnt >= 2*prev`, where `prev` is the previous `period`. The compare is done at WIDTH+1 bits, so doubling cannot wrap. `prev` updates on every accepted edge.
- **States:**
  - **IDLE:** first edge goes to MEAS and starts `cnt`. No `period_valid`.
  - **MEAS:** next edge sets `period` and `period_valid`=1, then goes to HUNT. No gap test.
  - **HUNT:** gap edge goes to SYNCED with `tooth_num`=0 and pulses `gap`. A normal edge stays in HUNT with `tooth_num` held at 0.
  - **SYNCED, normal edge:** `tooth_num`+1. If `tooth_num` was already TEETH-1, pulse `sync_lost` and go to HUNT, because a gap was expected.
  - **SYNCED, gap edge:** if `tooth_num` was TEETH-1, set `tooth_num`=0 and pulse `gap`. Otherwise pulse `sync_lost` and go to HUNT with `tooth_num`=0.
- **Overflow:** when `cnt` reaches all-ones:
  - `ovf`=1, `period_valid`=0, and the state goes to IDLE.
  - If the block was in SYNCED, `sync_lost` pulses.
  - The next edge then behaves as the first edge from IDLE.
- **Reset:**
  - `srst` wins over everything, including mid-period reset and a coincident edge.
  - State returns to IDLE and the synchroniser clears.
  - All outputs go to 0: `period`=0, `tooth_num`=0, `ovf`=0, `synced`=0, `tooth_edge`=0, `gap`=0, `sync_lost`=0, `period_valid`=0.
  - `cnt` and `prev` are also 0.

## Timing
- All outputs are registered.
- Latency: if `cap_in` is first sampled high at clock edge k, then `tooth_edge`, `period`, `gap`, `tooth_num` and `synced` all update at edge k+3, in the same cycle.
- `cap_in` must stay high and low for at least 2 clocks each. Shorter pulses may be missed.
- `gap` never asserts without `tooth_edge`.
- `sync_lost` coincides with `tooth_edge`, except on overflow, where it coincides with the saturation cycle.
- Minimum edge spacing is 3 clocks; below that, behaviour is undefined.

## Configuration
- Macro: `HWAG_GAP_NOISE_REJECT_EN`.
- **Defined:** an edge with `cnt < prev/4` (integer shift) and `period_valid`=1 is rejected as noise:
  - no `tooth_edge`;
  - `cnt` keeps counting;
  - state, `prev` and `tooth_num` are unchanged.
- **Undefined:** every detected edge is accepted and the rejection logic is absent.

## Test plan
- Reset then edges every 100 clocks → first `tooth_edge` with `period_valid`=0; second with `period`=100, `period_valid`=1; state HUNT, `synced`=0.
- 60-2 wheel, normal tooth 100 clocks, gap 300 → `gap` pulses on the 300 period, `tooth_num`=0, `synced`=1; then 57 normal teeth reach `tooth_num`=57, and the next 300 period pulses `gap` again with `tooth_num`=0.
- While synced, insert a gap at `tooth_num`=20 → `sync_lost` pulse, `synced`=0, `tooth_num`=0; the next correct gap resyncs.
- WIDTH=8, no edge for 255 clocks after sync → `ovf`=1, `sync_lost` pulse, `period_valid`=0; the next edge leaves `period_valid`=0 and the state goes to MEAS.
- `srst` asserted 50 clocks into a period while synced → next cycle all outputs are 0 and the state is IDLE; a pulse of `cap_in` on the reset cycle produces no `tooth_edge`.
- `HWAG_GAP_NOISE_REJECT_EN` defined, period 100, glitch edge 10 clocks after a tooth → no `tooth_edge`; the next real edge reports `period`=100.
